// File: rtl/alu_8bit.sv
// alu_8bit: 8-bit registered ALU for the execute stage.
// Result, condition flag and valid are registered, so results appear one
// cycle after issue. Throughput is one operation per cycle.
// Optional build macro ALU_STATUS_FLAGS_EN adds registered carry_o/ovf_o.
module alu_8bit #(
   parameter int WIDTH = 8                  // only 8 is supported
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] rs_i,
   input  logic [WIDTH-1:0] rt_i,
   input  logic [2:0]       opcode_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] alu_result_o,
   output logic             zero
`ifdef ALU_STATUS_FLAGS_EN
   ,
   output logic             carry_o,
   output logic             ovf_o
`endif
);

   typedef enum logic [2:0] {
      OP_AND = 3'b000,
      OP_ADD = 3'b001,
      OP_SLL = 3'b010,
      OP_SRL = 3'b011,
      OP_SUB = 3'b100,
      OP_SLT = 3'b101,
      OP_ABS = 3'b110,
      OP_SEQ = 3'b111
   } op_e;

   op_e              w_op;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] w_sll;
   logic [WIDTH-1:0] w_abs;
   logic             w_lt;
   logic             w_eq;
   logic [WIDTH-1:0] w_result;
   logic             w_flag;

   assign w_op   = op_e'(opcode_i);
   assign w_sum  = rs_i + rt_i;
   assign w_diff = rs_i - rt_i;
   assign w_lt   = (rs_i < rt_i);
   assign w_eq   = (rs_i == rt_i);
   // Two's-complement negate of a negative value; 0x80 wraps back to 0x80.
   assign w_abs  = rs_i[WIDTH-1] ? (~rs_i + 1'b1) : rs_i;
   // Any shift count of WIDTH or more clears the result.
   assign w_sll  = (rt_i[WIDTH-1:3] != '0) ? '0 : (rs_i << rt_i[2:0]);

   // Select the result for the current opcode.
   always_comb begin
      w_result = '0;
      unique case (w_op)
         OP_AND:  w_result = rs_i & rt_i;
         OP_ADD:  w_result = w_sum;
         OP_SLL:  w_result = w_sll;
         OP_SRL:  w_result = rs_i >> 1;
         OP_SUB:  w_result = w_diff;
         OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, w_lt};
         OP_ABS:  w_result = w_abs;
         OP_SEQ:  w_result = {{(WIDTH-1){1'b0}}, w_eq};
         default: w_result = '0;
      endcase
   end

   // Compares drive the flag directly; every other op reports zero-detect.
   always_comb begin
      w_flag = (w_result == '0);
      if (w_op == OP_SLT) w_flag = w_lt;
      if (w_op == OP_SEQ) w_flag = w_eq;
   end

   // Result/flag registers load only on valid; valid is a one-stage delay.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         valid_o      <= 1'b0;
         alu_result_o <= '0;
         zero         <= 1'b0;
      end else begin
         valid_o <= valid_i;
         if (valid_i) begin
            alu_result_o <= w_result;
            zero         <= w_flag;
         end
      end
   end

`ifdef ALU_STATUS_FLAGS_EN
   logic w_carry;
   logic w_ovf;

   // Carry of ADD shows up as a wrapped sum below an operand; SUB reports
   // borrow. Overflow is the usual sign-mismatch rule, plus ABS(0x80).
   always_comb begin
      w_carry = 1'b0;
      w_ovf   = 1'b0;
      unique case (w_op)
         OP_ADD: begin
            w_carry = (w_sum < rs_i);
            w_ovf   = (rs_i[WIDTH-1] == rt_i[WIDTH-1]) &&
                      (w_sum[WIDTH-1] != rs_i[WIDTH-1]);
         end
         OP_SUB: begin
            w_carry = w_lt;
            w_ovf   = (rs_i[WIDTH-1] != rt_i[WIDTH-1]) &&
                      (w_diff[WIDTH-1] != rs_i[WIDTH-1]);
         end
         OP_ABS: w_ovf = (rs_i == {1'b1, {(WIDTH-1){1'b0}}});
         default: begin
            w_carry = 1'b0;
            w_ovf   = 1'b0;
         end
      endcase
   end

   // Status flags follow the same reset and hold rules as the result.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         carry_o <= 1'b0;
         ovf_o   <= 1'b0;
      end else if (valid_i) begin
         carry_o <= w_carry;
         ovf_o   <= w_ovf;
      end
   end
`endif

endmodule

// File: tb/tb_alu_8bit.sv
// Bench for alu_8bit: vector table applied back-to-back with a scoreboard
// queue, plus hand-written reset and hold sequences.
module tb_alu_8bit;

   logic       clk_i = 1'b0;
   logic       rst_n_i;
   logic       valid_i;
   logic [7:0] rs_i;
   logic [7:0] rt_i;
   logic [2:0] opcode_i;
   logic       valid_o;
   logic [7:0] alu_result_o;
   logic       zero;
`ifdef ALU_STATUS_FLAGS_EN
   logic       carry_o;
   logic       ovf_o;
`endif

   alu_8bit #(.WIDTH(8)) dut (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .valid_i      (valid_i),
      .rs_i         (rs_i),
      .rt_i         (rt_i),
      .opcode_i     (opcode_i),
      .valid_o      (valid_o),
      .alu_result_o (alu_result_o),
      .zero         (zero)
`ifdef ALU_STATUS_FLAGS_EN
      ,
      .carry_o      (carry_o),
      .ovf_o        (ovf_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic       z;
      logic       c;
      logic       v;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] res, input logic z, input logic c, input logic v);
      vec_t t;
      t.op = op; t.a = a; t.b = b; t.res = res; t.z = z; t.c = c; t.v = v;
      return t;
   endfunction

   // Scoreboard: every valid output pops one expectation.
   always @(posedge clk_i) begin
      #1;
      if (valid_o === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_valid_o", 32'd1, 32'd0);
         end else begin
            vec_t e;
            e = sb.pop_front();
            chk($sformatf("result op%0d %h,%h", e.op, e.a, e.b), alu_result_o, e.res);
            chk($sformatf("zero op%0d %h,%h", e.op, e.a, e.b), zero, e.z);
`ifdef ALU_STATUS_FLAGS_EN
            chk($sformatf("carry op%0d %h,%h", e.op, e.a, e.b), carry_o, e.c);
            chk($sformatf("ovf op%0d %h,%h", e.op, e.a, e.b), ovf_o, e.v);
`endif
         end
      end
   end

   task automatic issue(input vec_t t);
      @(negedge clk_i);
      valid_i  = 1'b1;
      opcode_i = t.op;
      rs_i     = t.a;
      rt_i     = t.b;
      sb.push_back(t);
   endtask

   initial begin
      //            op     a      b      res    z     c     v
      vecs.push_back(mk(3'd0, 8'h55, 8'hAA, 8'h00, 1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(3'd0, 8'hFF, 8'hAA, 8'hAA, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(3'd1, 8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(3'd1, 8'h14, 8'h64, 8'h78, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(3'd1, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0));
      vecs.push_back(mk(3'd1, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1));
      vecs.push_back(mk(3'd4, 8'hFD, 8'hFA, 8'h03, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(3'd4, 8'hEC, 8'h04, 8'hE8, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(3'd4, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b1, 1'b0));
      vecs.push_back(mk(3'd4, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1));
      vecs.push_back(mk(3'd2, 8'h05, 8'h02, 8'h14, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(3'd2, 8'h05, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(3'd2, 8'h81, 8'h07, 8'h80, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(3'd2, 8'h01, 8'h08, 8'h00, 1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(3'd3, 8'hFE, 8'hFF, 8'h7F, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(3'd5, 8'h01, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(3'd5, 8'h01, 8'h05, 8'h01, 1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(3'd5, 8'h80, 8'h7F, 8'h00, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(3'd7, 8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(3'd7, 8'hFF, 8'h7F, 8'h00, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(3'd6, 8'h01, 8'h33, 8'h01, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(3'd6, 8'hFF, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(3'd6, 8'h80, 8'h00, 8'h80, 1'b0, 1'b0, 1'b1));

      // Reset state
      rst_n_i = 1'b0; valid_i = 1'b0; rs_i = '0; rt_i = '0; opcode_i = '0;
      #3;
      chk("rst valid_o", valid_o, 0);
      chk("rst result", alu_result_o, 0);
      chk("rst zero", zero, 0);
      @(negedge clk_i); rst_n_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      chk("post-rst idle result", alu_result_o, 0);

      // Back-to-back vectors, one per cycle
      for (int i = 0; i < vecs.size(); i++) issue(vecs[i]);
      @(negedge clk_i); valid_i = 1'b0;

      // Hold: two idle cycles keep the last result (ABS 0x80 -> 0x80, zero=0)
      repeat (2) begin
         @(posedge clk_i); #1;
         chk("hold valid_o", valid_o, 0);
         chk("hold result", alu_result_o, 8'h80);
         chk("hold zero", zero, 0);
      end

      // Asynchronous reset mid-run with valid_i high
      @(negedge clk_i);
      valid_i = 1'b1; opcode_i = 3'd1; rs_i = 8'h14; rt_i = 8'h64;
      #2 rst_n_i = 1'b0;
      #1;
      chk("async rst valid_o", valid_o, 0);
      chk("async rst result", alu_result_o, 0);
      chk("async rst zero", zero, 0);
      @(posedge clk_i); #1;
      chk("in rst result", alu_result_o, 0);
      @(negedge clk_i); rst_n_i = 1'b1; valid_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      chk("after rst idle valid_o", valid_o, 0);
      chk("after rst idle result", alu_result_o, 0);

      // First valid op after release updates outputs
      issue(mk(3'd4, 8'hEC, 8'h04, 8'hE8, 1'b0, 1'b0, 1'b0));
      @(negedge clk_i); valid_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #2;
      chk("scoreboard drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Watchdog
   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
